// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit.
//
// Multiply and divide share one shift register pair (hi/lo) and one
// operand register (b). Multiply runs an unsigned shift-add on operand
// magnitudes. Divide runs an unsigned restoring division on operand
// magnitudes. The sign is restored in a single fixup cycle.
//
// Ports
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   start   : request; accepted only when idle and flush is low
//   flush   : pipeline kill; aborts any operation in progress
//   select  : funct3 opcode (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   data1   : rs1 (multiplicand / dividend)
//   data2   : rs2 (multiplier / divisor)
//   result  : registered result; held until the next operation completes
//   busy    : high from the cycle after acceptance through the done cycle
//   done    : one-cycle pulse; result is valid in that cycle
module muldiv_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, FIN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            load_reg;   // first CALC cycle converts operands to magnitudes
  logic            spec_reg;   // special-case result already sits in lo_reg
  logic            neg_reg;    // negate the selected result in FIXUP
  logic            div_reg;
  logic            sa_reg;
  logic            sb_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] result_reg;
  logic            busy_reg;
  logic            done_reg;

  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

  // ------------------------------------------------------------------
  // Request decode (evaluated on the raw inputs at acceptance)
  // ------------------------------------------------------------------
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa_in;
  logic            sb_in;
  logic            neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    is_div   = select[2];
    // Signed divide ops have select[0]=0; MULH signs both, MULHSU only rs1.
    a_signed = is_div ? ~select[0] : (select == 3'b001 || select == 3'b010);
    b_signed = is_div ? ~select[0] : (select == 3'b001);
    sa_in    = a_signed & data1[XLEN-1];
    sb_in    = b_signed & data2[XLEN-1];
    // Remainder follows the dividend's sign; product and quotient follow
    // the xor of both signs.
    neg_in   = (is_div && select[1]) ? sa_in : (sa_in ^ sb_in);
    div_zero = is_div && (data2 == '0);
    div_ovf  = is_div && !select[0] && (data1 == MIN_INT) && (data2 == '1);
    if (div_zero) begin
      spec_val = select[1] ? data1 : '1;
    end else begin
      spec_val = select[1] ? '0 : MIN_INT;
    end
  end

  // ------------------------------------------------------------------
  // One CALC iteration: UNROLL chained single-bit steps
  // ------------------------------------------------------------------
  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    sum     = '0;
    shl     = '0;
    diff    = '0;
    ge      = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div_reg) begin
        // Partial remainder is always below the divisor, so the shifted
        // value fits in XLEN+1 bits and the accepted difference in XLEN.
        shl  = {hi_next, lo_next[XLEN-1]};
        ge   = shl >= {1'b0, b_reg};
        diff = shl[XLEN-1:0] - b_reg;
        hi_next = ge ? diff : shl[XLEN-1:0];
        lo_next = {lo_next[XLEN-2:0], ge};
      end else begin
        // Add the multiplicand when the multiplier LSB is set, then shift
        // the whole 2*XLEN product right by one.
        sum     = {1'b0, hi_next} + (lo_next[0] ? {1'b0, b_reg} : '0);
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo_next[XLEN-1:1]};
      end
    end
  end

  // ------------------------------------------------------------------
  // Sign fixup and result selection
  // ------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod     = {hi_reg, lo_reg};
    prod_fix = neg_reg ? -prod : prod;
    quo_fix  = neg_reg ? -lo_reg : lo_reg;
    rem_fix  = neg_reg ? -hi_reg : hi_reg;
    fix_val  = '0;
    if (spec_reg) begin
      fix_val = lo_reg;
    end else begin
      case (op_reg)
        3'b000:                   fix_val = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011:   fix_val = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:           fix_val = quo_fix;
        default:                  fix_val = rem_fix;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Control FSM and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      load_reg   <= 1'b0;
      spec_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      div_reg    <= 1'b0;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (state_reg != IDLE && flush) begin
      // Abort: no done pulse, result keeps its previous value.
      state_reg <= IDLE;
      load_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            op_reg   <= select;
            div_reg  <= is_div;
            sa_reg   <= sa_in;
            sb_reg   <= sb_in;
            neg_reg  <= neg_in;
            b_reg    <= data2;
            busy_reg <= 1'b1;
            if (div_zero || div_ovf) begin
              // Result is known now; skip the iterations entirely.
              spec_reg  <= 1'b1;
              lo_reg    <= spec_val;
              state_reg <= FIXUP;
            end else begin
              spec_reg  <= 1'b0;
              lo_reg    <= data1;
              load_reg  <= 1'b1;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (load_reg) begin
            // Negation kept off the acceptance path: take magnitudes here.
            load_reg <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= sa_reg ? -lo_reg : lo_reg;
            b_reg    <= sb_reg ? -b_reg : b_reg;
            cnt_reg  <= CW'(ITERS - 1);
          end else begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
              state_reg <= FIXUP;
            end
          end
        end
        FIXUP: begin
          result_reg <= fix_val;
          done_reg   <= 1'b1;
          state_reg  <= FIN;
        end
        default: begin
          // FIN: the done cycle; a start here is ignored.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed bench for muldiv_iter. A cycle-level reference
// model (countdown latency + plain integer arithmetic) is compared against
// busy/done/result every cycle; directed ops also carry literal expectations.
module tb_muldiv_iter;

  localparam int XLEN = 32;
  localparam int LAT1 = XLEN / 1 + 2;
  localparam int LAT4 = XLEN / 4 + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start4;
  logic        flush;
  logic [2:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic [31:0] result4;
  logic        busy4;
  logic        done4;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .select(select),
    .data1(data1), .data2(data2), .result(result), .busy(busy), .done(done)
  );

  muldiv_iter #(.XLEN(XLEN), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .flush(flush), .select(select),
    .data1(data1), .data2(data2), .result(result4), .busy(busy4), .done(done4)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] last_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hffffffff;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hffffffff));
  endfunction

  // ---------------- cycle model of the UNROLL=1 unit ----------------
  logic        m_busy, m_done;
  logic [31:0] m_result, m_pend;
  int          m_lat;

  always @(posedge clk) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_lat    <= 0;
    end else if (!m_busy) begin
      if (start && !flush) begin
        m_busy <= 1'b1;
        m_lat  <= is_special(select, data1, data2) ? 1 : LAT1;
        m_pend <= ref_op(select, data1, data2);
      end
    end else if (flush || m_done) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_lat == 1) begin
      m_done   <= 1'b1;
      m_result <= m_pend;
      m_lat    <= 0;
    end else begin
      m_lat <= m_lat - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle busy", busy, m_busy);
      check("cycle done", done, m_done);
      check("cycle result", result, m_result);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit use4);
    int k;
    bit seen;
    @(negedge clk);
    select = op; data1 = a; data2 = b;
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    while (k <= 200) begin
      @(negedge clk);
      if (k == 0) begin
        // Inputs after acceptance must be ignored.
        start = 1'b0; start4 = 1'b0;
        select = ~op; data1 = ~a; data2 = ~b;
      end
      if (use4 ? done4 : done) begin
        seen = 1'b1;
        break;
      end
      k++;
    end
    check({name, " latency"}, seen ? k : -1, exp_lat);
    check({name, " result"}, use4 ? result4 : result, exp);
    if (!use4) last_exp = exp;
    $display("op %-14s sel=%0d a=%h b=%h -> result=%h latency=%0d", name, op, a, b,
             use4 ? result4 : result, k);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t extra[10];

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; flush = 1'b0;
    select = '0; data1 = '0; data2 = '0; last_exp = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'h0);
    reset = 1'b0;

    // Directed vectors with literal expectations.
    run_op("MUL -1*-1",   3'd0, 32'hffffffff, 32'hffffffff, 32'h00000001, LAT1, 1'b0);
    run_op("MULH",        3'd1, 32'haaaaaaab, 32'h0002fe7d, 32'hffff0081, LAT1, 1'b0);
    run_op("MULHU",       3'd3, 32'haaaaaaab, 32'h0002fe7d, 32'h0001fefe, LAT1, 1'b0);
    run_op("MULHSU",      3'd2, 32'h80000000, 32'hffff8000, 32'h80004000, LAT1, 1'b0);
    run_op("MULHU min",   3'd3, 32'h80000000, 32'hffff8000, 32'h7fffc000, LAT1, 1'b0);
    run_op("DIV -7/2",    3'd4, 32'hfffffff9, 32'h00000002, 32'hfffffffd, LAT1, 1'b0);
    run_op("REM -7/2",    3'd6, 32'hfffffff9, 32'h00000002, 32'hffffffff, LAT1, 1'b0);
    run_op("DIVU max/1",  3'd5, 32'hffffffff, 32'h00000001, 32'hffffffff, LAT1, 1'b0);
    run_op("DIV 5/0",     3'd4, 32'h00000005, 32'h00000000, 32'hffffffff, 1, 1'b0);
    run_op("REMU 5/0",    3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1, 1'b0);
    run_op("DIV ovf",     3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1, 1'b0);
    run_op("REM ovf",     3'd6, 32'h80000000, 32'hffffffff, 32'h00000000, 1, 1'b0);

    // Mixed-sign vectors, expectations from the reference arithmetic.
    extra[0] = '{3'd0, 32'h12345678, 32'h9abcdef0};
    extra[1] = '{3'd1, 32'h80000000, 32'h80000000};
    extra[2] = '{3'd1, 32'h7fffffff, 32'hffffffff};
    extra[3] = '{3'd2, 32'hfffffffe, 32'h00000003};
    extra[4] = '{3'd4, 32'h00000064, 32'hfffffff9};
    extra[5] = '{3'd6, 32'hffffff9c, 32'hfffffff9};
    extra[6] = '{3'd5, 32'h87654321, 32'h0000f00d};
    extra[7] = '{3'd7, 32'h87654321, 32'h0000f00d};
    extra[8] = '{3'd6, 32'h80000000, 32'h00000003};
    extra[9] = '{3'd5, 32'h00000003, 32'hffffffff};
    foreach (extra[i]) begin
      run_op($sformatf("vec%0d", i), extra[i].op, extra[i].a, extra[i].b,
             ref_op(extra[i].op, extra[i].a, extra[i].b),
             is_special(extra[i].op, extra[i].a, extra[i].b) ? 1 : LAT1, 1'b0);
    end

    // UNROLL=4 instance.
    run_op("u4 MUL -1*-1", 3'd0, 32'hffffffff, 32'hffffffff, 32'h00000001, LAT4, 1'b1);
    run_op("u4 DIV -7/2",  3'd4, 32'hfffffff9, 32'h00000002, 32'hfffffffd, LAT4, 1'b1);
    run_op("u4 MULHSU",    3'd2, 32'h80000000, 32'hffff8000, 32'h80004000, LAT4, 1'b1);
    run_op("u4 REMU 5/0",  3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1, 1'b1);

    // START held through BUSY: accepts at edges 0 and 36 only.
    @(negedge clk);
    select = 3'd0; data1 = 32'd6; data2 = 32'd9; start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 39) start = 1'b0;
      if (done) cnt++;
    end
    check("held start done count", cnt, 2);
    last_exp = 32'd54;
    $display("op held-start   done pulses=%0d", cnt);

    // FLUSH during CALC: no done, result unchanged, busy low next cycle.
    @(negedge clk);
    select = 3'd0; data1 = 32'd123; data2 = 32'd456; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush result", result, last_exp);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("flush no done", cnt, 0);
    $display("op flush        result=%h", result);

    // START with FLUSH in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", busy, 1'b0);
    @(negedge clk);
    check("start+flush done", done, 1'b0);
    $display("op start+flush  busy=%0b", busy);

    // Reset mid-CALC, then a normal multiply.
    @(negedge clk);
    select = 3'd3; data1 = 32'hdeadbeef; data2 = 32'h01234567; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset result", result, 32'h0);
    $display("op mid-reset    result=%h busy=%0b", result, busy);
    run_op("MUL 3*7", 3'd0, 32'd3, 32'd7, 32'd21, LAT1, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
